vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator. It is the successor to the fixed 640x360 letterboxed generator.
- All horizontal and vertical timings, sync polarities and the letterbox window are parameters.
- Adds a line-start pulse, an early-fetch strobe for pipelined pixel sources, and a free-running frame counter.
- Sits between the pixel-strobe divider and the framebuffer/sprite renderers.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator.
// Holds the standard 640x480@60 and 800x600@60 timing sets, the sync
// polarity encodings, and the derived line/frame totals and active-start
// offsets so that instantiating code never re-derives them by hand.
package vga_timing_pkg;

  // Sync polarity encodings: the level a sync output takes while asserted.
  localparam int POL_LOW  = 0;
  localparam int POL_HIGH = 1;

  // Sum of the three blanking segments that precede the active region.
  function automatic int porch_total(input int fp, input int sync, input int bp);
    return fp + sync + bp;
  endfunction

  // 640x480 @ 60 Hz (25.175 MHz pixel rate)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_HS_POL   = POL_LOW;
  localparam int VGA640_VS_POL   = POL_LOW;
  localparam int VGA640_HA_STA   = porch_total(VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int VGA640_H_TOTAL  = VGA640_HA_STA + VGA640_H_ACTIVE;
  localparam int VGA640_V_TOTAL  = VGA640_V_ACTIVE +
                                   porch_total(VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

  // 800x600 @ 60 Hz (40 MHz pixel rate)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_HS_POL   = POL_HIGH;
  localparam int SVGA800_VS_POL   = POL_HIGH;
  localparam int SVGA800_HA_STA   = porch_total(SVGA800_H_FP, SVGA800_H_SYNC, SVGA800_H_BP);
  localparam int SVGA800_H_TOTAL  = SVGA800_HA_STA + SVGA800_H_ACTIVE;
  localparam int SVGA800_V_TOTAL  = SVGA800_V_ACTIVE +
                                    porch_total(SVGA800_V_FP, SVGA800_V_SYNC, SVGA800_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the VGA generator.
// Counts 0..TOTAL-1 while en is high and decodes the sync and active
// windows of the current position.
// Ports:
//   clk       clock
//   srst      synchronous active-high reset, forces cnt to 0
//   en        advance enable
//   cnt       current position
//   wrap      high when en is high and cnt is at TOTAL-1 (next step wraps)
//   in_sync   SYNC_STA <= cnt < SYNC_END
//   in_active ACT_STA  <= cnt < ACT_END
module vga_axis_counter #(
  parameter int TOTAL    = 800,
  parameter int SYNC_STA = 16,
  parameter int SYNC_END = 112,
  parameter int ACT_STA  = 160,
  parameter int ACT_END  = 800,
  localparam int CW      = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_active
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  assign wrap = en & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

  assign in_sync   = (int'(cnt) >= SYNC_STA) && (int'(cnt) < SYNC_END);
  assign in_active = (int'(cnt) >= ACT_STA)  && (int'(cnt) < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a letterbox window.
// Horizontal order: front porch, sync, back porch, active.
// Vertical order:   active, front porch, sync, back porch.
// All level outputs decode the registered h/v counters combinationally;
// pulses are additionally qualified by the pixel strobe so each event lasts
// exactly one i_clk cycle.
// Ports:
//   i_clk, i_rst (sync, active high), i_pix_stb (one clock per pixel)
//   o_hs, o_vs             sync outputs, asserted level per HS_POL/VS_POL
//   o_blanking             outside the H/V active region
//   o_active, o_fetch      drawing inside the window / same, FETCH_LEAD early
//   o_line_start           first active pixel of each window line
//   o_screenend, o_animate last pixel of frame / of last window line
//   o_x, o_y, o_frame      window coordinates and completed-frame count
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter int HS_POL     = VGA640_HS_POL,
  parameter int VS_POL     = VGA640_VS_POL,
  parameter int WIN_Y_STA  = 60,
  parameter int WIN_Y_END  = 420,
  parameter int FETCH_LEAD = 2,
  parameter int FRAME_W    = 16,
  localparam int XW        = $clog2(H_ACTIVE),
  localparam int YW        = $clog2(WIN_Y_END - WIN_Y_STA)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_blanking,
  output logic               o_active,
  output logic               o_fetch,
  output logic               o_line_start,
  output logic               o_screenend,
  output logic               o_animate,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int HA_STA  = porch_total(H_FP, H_SYNC, H_BP);
  localparam int H_TOTAL = HA_STA + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + porch_total(V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  generate
    if (WIN_Y_END > V_ACTIVE) begin : g_bad_win_end
      $error("vga_timing_gen: WIN_Y_END must not exceed V_ACTIVE");
    end
    if (WIN_Y_STA >= WIN_Y_END) begin : g_bad_win_order
      $error("vga_timing_gen: WIN_Y_STA must be below WIN_Y_END");
    end
    if (FETCH_LEAD >= HA_STA) begin : g_bad_lead
      $error("vga_timing_gen: FETCH_LEAD must be below the horizontal blanking length");
    end
  endgenerate

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               h_wrap, v_wrap;
  logic               h_sync_on, v_sync_on;
  logic               h_act, v_act;
  logic               win_v;
  logic               fetch_h;
  logic               pulse_en;
  logic [FRAME_W-1:0] frame_reg;

  vga_axis_counter #(
    .TOTAL    (H_TOTAL),
    .SYNC_STA (H_FP),
    .SYNC_END (H_FP + H_SYNC),
    .ACT_STA  (HA_STA),
    .ACT_END  (H_TOTAL)
  ) u_h_axis (
    .clk       (i_clk),
    .srst      (i_rst),
    .en        (i_pix_stb),
    .cnt       (h_cnt),
    .wrap      (h_wrap),
    .in_sync   (h_sync_on),
    .in_active (h_act)
  );

  // The vertical axis steps once per line, i.e. on the horizontal wrap.
  vga_axis_counter #(
    .TOTAL    (V_TOTAL),
    .SYNC_STA (V_ACTIVE + V_FP),
    .SYNC_END (V_ACTIVE + V_FP + V_SYNC),
    .ACT_STA  (0),
    .ACT_END  (V_ACTIVE)
  ) u_v_axis (
    .clk       (i_clk),
    .srst      (i_rst),
    .en        (h_wrap),
    .cnt       (v_cnt),
    .wrap      (v_wrap),
    .in_sync   (v_sync_on),
    .in_active (v_act)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_reg <= '0;
    end else if (v_wrap) begin
      frame_reg <= frame_reg + FRAME_W'(1);
    end
  end

  assign o_frame = frame_reg;

  assign win_v   = (int'(v_cnt) >= WIN_Y_STA) && (int'(v_cnt) < WIN_Y_END);
  assign fetch_h = (int'(h_cnt) >= HA_STA - FETCH_LEAD) &&
                   (int'(h_cnt) <  H_TOTAL - FETCH_LEAD);

  assign o_hs       = h_sync_on ? HS_ON : ~HS_ON;
  assign o_vs       = v_sync_on ? VS_ON : ~VS_ON;
  assign o_blanking = ~h_act | ~v_act;
  assign o_active   = h_act & win_v;
  assign o_fetch    = fetch_h & win_v;

  always_comb begin
    o_x = '0;
    if (h_act) begin
      o_x = XW'(int'(h_cnt) - HA_STA);
    end
  end

  // Below the window y holds at 0, above it clamps to the last window line.
  always_comb begin
    o_y = '0;
    if (int'(v_cnt) >= WIN_Y_END) begin
      o_y = YW'(WIN_Y_END - WIN_Y_STA - 1);
    end else if (int'(v_cnt) >= WIN_Y_STA) begin
      o_y = YW'(int'(v_cnt) - WIN_Y_STA);
    end
  end

  // Reset outranks the strobe, so a restart never emits a stray event pulse.
  assign pulse_en     = i_pix_stb & ~i_rst;
  assign o_line_start = pulse_en & (int'(h_cnt) == HA_STA) & win_v;
  assign o_screenend  = v_wrap & ~i_rst;
  assign o_animate    = h_wrap & ~i_rst & (int'(v_cnt) == WIN_Y_END - 1);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, wys, wye, fl, fw;
  } tp_t;

  typedef struct {
    logic [31:0] hs, vs, blank, active, fetch, ls, se, an, x, y, frame;
  } out_t;

  // Small instance: short frames so many frames and frame-counter wraps fit.
  localparam int S_HA = 16, S_HFP = 2, S_HSW = 3, S_HBP = 3;
  localparam int S_VA = 12, S_VFP = 1, S_VSW = 2, S_VBP = 2;
  localparam int S_WYS = 3, S_WYE = 9, S_FL = 2, S_FW = 3;
  localparam int NCYC = 48900;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, stb_s, rst_d, stb_d;

  logic s_hs, s_vs, s_blank, s_active, s_fetch, s_ls, s_se, s_an;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic [2:0] s_frame;
  logic d_hs, d_vs, d_blank, d_active, d_fetch, d_ls, d_se, d_an;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic [15:0] d_frame;
  logic w_hs, w_vs, w_blank, w_active, w_fetch, w_ls, w_se, w_an;
  logic [9:0] w_x;
  logic [8:0] w_y;
  logic [15:0] w_frame;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
    .HS_POL(0), .VS_POL(1), .WIN_Y_STA(S_WYS), .WIN_Y_END(S_WYE),
    .FETCH_LEAD(S_FL), .FRAME_W(S_FW)
  ) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_pix_stb(stb_s),
    .o_hs(s_hs), .o_vs(s_vs), .o_blanking(s_blank), .o_active(s_active),
    .o_fetch(s_fetch), .o_line_start(s_ls), .o_screenend(s_se),
    .o_animate(s_an), .o_x(s_x), .o_y(s_y), .o_frame(s_frame)
  );

  vga_timing_gen dut_d (
    .i_clk(clk), .i_rst(rst_d), .i_pix_stb(stb_d),
    .o_hs(d_hs), .o_vs(d_vs), .o_blanking(d_blank), .o_active(d_active),
    .o_fetch(d_fetch), .o_line_start(d_ls), .o_screenend(d_se),
    .o_animate(d_an), .o_x(d_x), .o_y(d_y), .o_frame(d_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC),
    .H_BP(SVGA800_H_BP), .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP),
    .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP), .HS_POL(1), .VS_POL(1)
  ) dut_w (
    .i_clk(clk), .i_rst(rst_d), .i_pix_stb(stb_d),
    .o_hs(w_hs), .o_vs(w_vs), .o_blanking(w_blank), .o_active(w_active),
    .o_fetch(w_fetch), .o_line_start(w_ls), .o_screenend(w_se),
    .o_animate(w_an), .o_x(w_x), .o_y(w_y), .o_frame(w_frame)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      if (errors >= 100) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  endtask

  // Reference: the DUT position is fully determined by the number of strobes
  // taken since the last reset; derive every output from that index.
  function automatic out_t model(input tp_t p, input longint n, input bit stb, input bit rst);
    out_t e;
    int hsta, ht, vt, h, v;
    bit win, fire;
    longint fr;
    hsta = p.hfp + p.hsw + p.hbp;
    ht   = hsta + p.ha;
    vt   = p.va + p.vfp + p.vsw + p.vbp;
    h    = int'(n % ht);
    v    = int'((n / ht) % vt);
    fr   = (n / (ht * vt)) % (longint'(1) << p.fw);
    win  = (v >= p.wys) && (v < p.wye);
    fire = stb && !rst;
    e.hs     = ((h >= p.hfp) && (h < p.hfp + p.hsw)) ? 32'(p.hpol) : 32'(1 - p.hpol);
    e.vs     = ((v >= p.va + p.vfp) && (v < p.va + p.vfp + p.vsw)) ? 32'(p.vpol) : 32'(1 - p.vpol);
    e.blank  = 32'((h < hsta) || (v >= p.va));
    e.active = 32'((h >= hsta) && win);
    e.fetch  = 32'(win && (h >= hsta - p.fl) && (h < ht - p.fl));
    e.ls     = 32'(fire && (h == hsta) && win);
    e.se     = 32'(fire && (h == ht - 1) && (v == vt - 1));
    e.an     = 32'(fire && (h == ht - 1) && (v == p.wye - 1));
    e.x      = (h >= hsta) ? 32'(h - hsta) : 32'd0;
    e.y      = (v < p.wys) ? 32'd0 : (v >= p.wye) ? 32'(p.wye - p.wys - 1) : 32'(v - p.wys);
    e.frame  = 32'(fr);
    return e;
  endfunction

  task automatic cmp(input string tag, input out_t a, input out_t e);
    chk({tag, " hs"}, a.hs, e.hs);
    chk({tag, " vs"}, a.vs, e.vs);
    chk({tag, " blanking"}, a.blank, e.blank);
    chk({tag, " active"}, a.active, e.active);
    chk({tag, " fetch"}, a.fetch, e.fetch);
    chk({tag, " line_start"}, a.ls, e.ls);
    chk({tag, " screenend"}, a.se, e.se);
    chk({tag, " animate"}, a.an, e.an);
    chk({tag, " x"}, a.x, e.x);
    chk({tag, " y"}, a.y, e.y);
    chk({tag, " frame"}, a.frame, e.frame);
  endtask

  tp_t ps, pd, pw;
  longint n_s, n_d, n_w;
  int h_s, v_s;
  int det_hold, det_stage, pin_hits;
  bit det_done, seen_se, pend_se, prev_whs;
  int hs_low_cnt, hs_high_cnt, rises;
  longint rise0;
  out_t a, e;

  initial begin
    ps = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 0, 1, S_WYS, S_WYE, S_FL, S_FW};
    pd = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 60, 420, 2, 16};
    pw = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 60, 420, 2, 16};
    rst_s = 1'b1; rst_d = 1'b1; stb_s = 1'b0; stb_d = 1'b1;
    n_s = 0; n_d = 0; n_w = 0;
    det_hold = 0; det_stage = 0; det_done = 0; pin_hits = 0;
    seen_se = 0; pend_se = 0; prev_whs = 0;
    hs_low_cnt = 0; hs_high_cnt = 0; rises = 0; rise0 = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (rst_s) n_s = 0; else if (stb_s) n_s++;
      if (rst_d) begin n_d = 0; n_w = 0; end
      else if (stb_d) begin n_d++; n_w++; end
      h_s = int'(n_s % 24);
      v_s = int'((n_s / 24) % 17);

      #1;
      stb_d = 1'b1;
      rst_d = (cyc < 3);
      stb_s = 1'($urandom_range(0, 1));
      if (cyc < 3) begin
        rst_s = 1'b1;
      end else if (det_hold > 0) begin
        rst_s = 1'b1; stb_s = 1'b1; det_hold--;
      end else if (!det_done && cyc > 3000 && h_s == 12 && v_s == 5) begin
        rst_s = 1'b1; stb_s = 1'b1; det_hold = 1; det_done = 1; det_stage = 1;
      end else if (cyc > 20000 && $urandom_range(0, 4999) == 0) begin
        rst_s = 1'b1;
      end else begin
        rst_s = 1'b0;
      end

      @(negedge clk);
      a = '{32'(s_hs), 32'(s_vs), 32'(s_blank), 32'(s_active), 32'(s_fetch), 32'(s_ls),
            32'(s_se), 32'(s_an), 32'(s_x), 32'(s_y), 32'(s_frame)};
      e = model(ps, n_s, stb_s, rst_s);
      cmp($sformatf("small n=%0d", n_s), a, e);
      a = '{32'(d_hs), 32'(d_vs), 32'(d_blank), 32'(d_active), 32'(d_fetch), 32'(d_ls),
            32'(d_se), 32'(d_an), 32'(d_x), 32'(d_y), 32'(d_frame)};
      e = model(pd, n_d, stb_d, rst_d);
      cmp($sformatf("vga640 n=%0d", n_d), a, e);
      a = '{32'(w_hs), 32'(w_vs), 32'(w_blank), 32'(w_active), 32'(w_fetch), 32'(w_ls),
            32'(w_se), 32'(w_an), 32'(w_x), 32'(w_y), 32'(w_frame)};
      e = model(pw, n_w, stb_d, rst_d);
      cmp($sformatf("svga800 n=%0d", n_w), a, e);

      // Hand-computed anchors for the 640x480 instance (strobe every clock).
      if (!rst_d) begin
        if (n_d < 800 && d_hs == 1'b0) hs_low_cnt++;
        if (n_d == 800) begin chk("pin 640 hs low pixels per line", 32'(hs_low_cnt), 32'd96); pin_hits++; end
        if (n_d == 59 * 800 + 160) begin
          chk("pin v59 active", 32'(d_active), 32'd0);
          chk("pin v59 y", 32'(d_y), 32'd0); pin_hits++;
        end
        if (n_d == 60 * 800 + 157) begin chk("pin v60 h157 fetch", 32'(d_fetch), 32'd0); pin_hits++; end
        if (n_d == 60 * 800 + 158) begin
          chk("pin v60 h158 fetch", 32'(d_fetch), 32'd1);
          chk("pin v60 h158 active", 32'(d_active), 32'd0); pin_hits++;
        end
        if (n_d == 60 * 800 + 160) begin
          chk("pin v60 h160 active", 32'(d_active), 32'd1);
          chk("pin v60 h160 x", 32'(d_x), 32'd0);
          chk("pin v60 h160 y", 32'(d_y), 32'd0);
          chk("pin v60 h160 line_start", 32'(d_ls), 32'd1); pin_hits++;
        end
        if (n_d == 60 * 800 + 161) begin chk("pin v60 h161 line_start", 32'(d_ls), 32'd0); pin_hits++; end
        if (n_d == 60 * 800 + 798) begin
          chk("pin v60 h798 fetch", 32'(d_fetch), 32'd0);
          chk("pin v60 h798 active", 32'(d_active), 32'd1); pin_hits++;
        end
        if (n_d == 60 * 800 + 799) begin chk("pin v60 h799 x", 32'(d_x), 32'd639); pin_hits++; end

        // 800x600 with positive syncs.
        if (n_w < 1056 && w_hs == 1'b1) hs_high_cnt++;
        if (n_w == 1056) begin chk("pin 800 hs high pixels per line", 32'(hs_high_cnt), 32'd128); pin_hits++; end
        if (w_hs && !prev_whs) begin
          rises++;
          if (rises == 1) rise0 = n_w;
          if (rises == 2) begin chk("pin 800 line period", 32'(n_w - rise0), 32'd1056); pin_hits++; end
        end
        prev_whs = w_hs;
      end

      // Small instance anchors (first frame, before any reset).
      if (!rst_s && !det_done) begin
        if (n_s == 12 * 24 + 5) begin
          chk("pin small v12 vs", 32'(s_vs), 32'd0);
          chk("pin small v12 blanking", 32'(s_blank), 32'd1); pin_hits++;
        end
        if (n_s == 13 * 24 + 5) begin chk("pin small v13 vs", 32'(s_vs), 32'd1); pin_hits++; end
        if (n_s == 15 * 24) begin chk("pin small v15 vs", 32'(s_vs), 32'd0); pin_hits++; end
        if (n_s == 10 * 24 + 3) begin chk("pin small v10 y clamp", 32'(s_y), 32'd5); pin_hits++; end
        if (n_s == 3 * 24 + 8) begin
          chk("pin small v3 h8 active", 32'(s_active), 32'd1);
          chk("pin small v3 h8 x", 32'(s_x), 32'd0); pin_hits++;
        end
      end
      if (pend_se) begin
        chk("pin small frame after first screenend", 32'(s_frame), 32'd1);
        pend_se = 0; pin_hits++;
      end
      if (s_se && !seen_se) begin
        chk("pin small frame at first screenend", 32'(s_frame), 32'd0);
        seen_se = 1; pend_se = 1;
      end

      // Mid-frame reset: one clock after it is sampled everything is at origin.
      if (det_stage == 2) begin
        chk("pin reset x", 32'(s_x), 32'd0);
        chk("pin reset y", 32'(s_y), 32'd0);
        chk("pin reset frame", 32'(s_frame), 32'd0);
        chk("pin reset blanking", 32'(s_blank), 32'd1);
        chk("pin reset active", 32'(s_active), 32'd0);
        chk("pin reset line_start", 32'(s_ls), 32'd0);
        chk("pin reset screenend", 32'(s_se), 32'd0);
        det_stage = 0; pin_hits++;
      end else if (det_stage == 1) begin
        det_stage = 2;
      end
    end

    chk("anchors reached", 32'(pin_hits >= 15), 32'd1);
    chk("mid-frame reset exercised", 32'(det_done), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
